axis_packet_sink: RTL and testbench

AXIS_PACKET_SINK -- requirements
Module: axis_packet_sink

---
 rtl/axis_packet_sink.sv | 138 +++++++++++++
 tb/tb_axis_packet_sink.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_sink.sv
// AXI-Stream packet sink.
// Buffers one packet of up to NUMBER_OF_INPUT_WORDS beats and checks it.
// Each beat must carry its 1-based index, have all byte strobes set, and
// assert TLAST on the final buffer slot only. Once a packet is complete,
// the buffer is drained one word per RD_EN pulse, and then the sink
// re-opens for the next packet.
module axis_packet_sink #(
    parameter int C_S_AXIS_TDATA_WIDTH  = 32,
    parameter int NUMBER_OF_INPUT_WORDS = 8
) (
    input  logic                                         S_AXIS_ACLK,
    input  logic                                         S_AXIS_ARESET,
    input  logic                                         S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]              S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]            S_AXIS_TSTRB,
    input  logic                                         S_AXIS_TLAST,
    output logic                                         S_AXIS_TREADY,
    input  logic                                         RD_EN,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]              RD_DATA,
    output logic                                         RD_VALID,
    output logic                                         PKT_DONE,
    output logic [$clog2(NUMBER_OF_INPUT_WORDS+1)-1:0]   PKT_LEN,
    output logic                                         PKT_ERR,
    output logic [15:0]                                  PKT_COUNT
);

    localparam int LEN_W = $clog2(NUMBER_OF_INPUT_WORDS + 1);
    localparam int PTR_W = (NUMBER_OF_INPUT_WORDS > 1) ? $clog2(NUMBER_OF_INPUT_WORDS) : 1;
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(NUMBER_OF_INPUT_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECEIVE = 2'b01,
        FULL    = 2'b10
    } state_e;

    state_e                            state_q, state_d;
    logic [LEN_W-1:0]                  len_q, len_d;       // doubles as write pointer
    logic [LEN_W-1:0]                  rd_ptr_q, rd_ptr_d;
    logic                              err_q, err_d;
    logic [15:0]                       count_q, count_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                              rd_valid_q, rd_valid_d;
    logic                              wr_en;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   buffer [NUMBER_OF_INPUT_WORDS];

    logic                              last_slot;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   exp_data;
    logic                              beat_err;

    // Content/protocol check of the beat currently presented on the bus.
    always_comb begin
        last_slot = (len_q == LAST_IDX);
        exp_data  = C_S_AXIS_TDATA_WIDTH'(len_q + 1'b1);
        // TLAST must coincide with the last buffer slot: early means short, missing means long.
        beat_err  = (S_AXIS_TDATA != exp_data) || !(&S_AXIS_TSTRB) || (S_AXIS_TLAST != last_slot);
    end

    // Next-state and datapath decode for receive and drain.
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: state_d = RECEIVE;
            RECEIVE: begin
                if (S_AXIS_TVALID) begin
                    wr_en = 1'b1;
                    len_d = len_q + 1'b1;
                    err_d = err_q | beat_err;
                    if (S_AXIS_TLAST || last_slot) begin
                        state_d = FULL;
                        count_d = count_q + 16'd1;
                    end
                end
            end
            FULL: begin
                if (RD_EN) begin
                    rd_data_d  = buffer[rd_ptr_q[PTR_W-1:0]];
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == len_q - 1'b1) begin
                        state_d  = RECEIVE;
                        len_d    = '0;
                        rd_ptr_d = '0;
                        err_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and control registers with synchronous reset.
    // NOTE: non-blocking assignments here so every register samples the pre-edge values, independent of statement order.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Packet buffer write port.
    // NOTE: the buffer has no reset; stale words are unreachable because the length and pointers are cleared.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr_en) begin
            buffer[len_q[PTR_W-1:0]] <= S_AXIS_TDATA;
        end
    end

    assign S_AXIS_TREADY = (state_q == RECEIVE);
    assign PKT_DONE      = (state_q == FULL);
    assign PKT_LEN       = len_q;
    assign PKT_ERR       = err_q;
    assign PKT_COUNT     = count_q;
    assign RD_DATA       = rd_data_q;
    assign RD_VALID      = rd_valid_q;

endmodule

// File: tb/tb_axis_packet_sink.sv
// Self-checking bench for axis_packet_sink with a scoreboard.
// Accepted beats push the expected drain words and packet status.
// The monitor pops and compares them when the DUT reports a packet or read data.
module tb_axis_packet_sink;

    typedef struct {
        int len;
        bit err;
        int count;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        pkt_done;
    logic [3:0]  pkt_len;
    logic        pkt_err;
    logic [15:0] pkt_count;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] data_q[$];
    pkt_t        pkt_q[$];
    int          m_len   = 0;
    bit          m_err   = 0;
    int          m_count = 0;
    logic [31:0] last_rd = '0;
    bit          prev_done = 0;
    bit          drain_en  = 0;
    bit          rd_rand   = 0;

    axis_packet_sink #(
        .C_S_AXIS_TDATA_WIDTH (32),
        .NUMBER_OF_INPUT_WORDS(8)
    ) dut (
        .S_AXIS_ACLK  (clk),
        .S_AXIS_ARESET(rst),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TDATA (tdata),
        .S_AXIS_TSTRB (tstrb),
        .S_AXIS_TLAST (tlast),
        .S_AXIS_TREADY(tready),
        .RD_EN        (rd_en),
        .RD_DATA      (rd_data),
        .RD_VALID     (rd_valid),
        .PKT_DONE     (pkt_done),
        .PKT_LEN      (pkt_len),
        .PKT_ERR      (pkt_err),
        .PKT_COUNT    (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of one accepted beat.
    task automatic model_accept(input logic [31:0] d, input logic [3:0] s, input logic l);
        bit e;
        e = (d != 32'(m_len + 1)) || (s != 4'hF) || (l && m_len != 7) || (!l && m_len == 7);
        m_err = m_err | e;
        data_q.push_back(d);
        m_len++;
        if (l || m_len == 8) begin
            pkt_t p;
            m_count++;
            p.len   = m_len;
            p.err   = m_err;
            p.count = m_count;
            pkt_q.push_back(p);
            m_len = 0;
            m_err = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                             input bit rv, input int budget);
        int waited;
        bit done;
        waited = 0;
        done   = 0;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        while (!done) begin
            tvalid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid && tready) begin
                model_accept(d, s, l);
                done = 1;
            end
            @(negedge clk);
            waited++;
            if (!done && waited > budget) begin
                check("beat_timeout", 32'(waited), 32'(budget));
                done = 1;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int last_at, input int bad_data_at,
                            input int bad_strb_at, input bit rv);
        for (int k = 0; k < n; k++) begin
            send_beat((k == bad_data_at) ? 32'hDEAD : 32'(k + 1),
                      (k == bad_strb_at) ? 4'b0111 : 4'hF,
                      (k == last_at), rv, 200);
        end
    endtask

    task automatic wait_drained();
        int cyc;
        cyc = 0;
        while ((data_q.size() != 0 || pkt_q.size() != 0 || pkt_done) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) check("drain_timeout", 32'(data_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
        data_q.delete();
        pkt_q.delete();
        m_len   = 0;
        m_err   = 0;
        m_count = 0;
        last_rd = '0;
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_pkt_len", 32'(pkt_len), 32'd0);
        check("rst_pkt_err", 32'(pkt_err), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        rst = 1'b0;
        check("idle_tready", 32'(tready), 32'd0);
        @(negedge clk);
        check("recv_tready", 32'(tready), 32'd1);
    endtask

    // Drain driver: pulses RD_EN while a packet is held.
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = !rst && drain_en && pkt_done && (rd_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    end

    // Monitor: compares read data and packet status against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                prev_done = 0;
                continue;
            end
            if (rd_valid) begin
                if (data_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
                else check("rd_data", rd_data, data_q.pop_front());
                last_rd = rd_data;
            end else begin
                check("rd_hold", rd_data, last_rd);
            end
            if (pkt_done && !prev_done) begin
                if (pkt_q.size() == 0) begin
                    check("pkt_unexpected", 32'(pkt_done), 32'd0);
                end else begin
                    pkt_t p;
                    p = pkt_q.pop_front();
                    check("pkt_len", 32'(pkt_len), 32'(p.len));
                    check("pkt_err", 32'(pkt_err), 32'(p.err));
                    check("pkt_count", 32'(pkt_count), 32'(p.count));
                    check("full_tready", 32'(tready), 32'd0);
                end
            end
            if (!pkt_done && prev_done) begin
                check("reopen_err", 32'(pkt_err), 32'd0);
                check("reopen_len", 32'(pkt_len), 32'd0);
                check("reopen_tready", 32'(tready), 32'd1);
            end
            prev_done = pkt_done;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        tvalid = 1'b0;
        tdata  = '0;
        tstrb  = '0;
        tlast  = 1'b0;
        do_reset();

        // Nominal packet, immediate drain.
        drain_en = 1;
        rd_rand  = 0;
        send_pkt(8, 7, -1, -1, 0);
        wait_drained();

        // Backpressure on both sides.
        rd_rand = 1;
        for (int i = 0; i < 3; i++) begin
            send_pkt(8, 7, -1, -1, 1);
        end
        wait_drained();

        // Short packet.
        send_pkt(5, 4, -1, -1, 1);
        wait_drained();

        // Bad data, then bad strobe, on the third beat.
        send_pkt(8, 7, 2, -1, 0);
        wait_drained();
        send_pkt(8, 7, -1, 2, 0);
        wait_drained();

        // Missing TLAST: the ninth beat stalls until the drain completes.
        send_pkt(9, 8, -1, -1, 0);
        wait_drained();

        // Reset after four accepted beats; the count restarts.
        drain_en = 0;
        send_pkt(4, -1, -1, -1, 0);
        do_reset();
        drain_en = 1;
        rd_rand  = 0;
        send_pkt(8, 7, -1, -1, 0);
        wait_drained();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
